rtc_reg_bank_xfer: RTL
======================

// Module: rtc_reg_bank_xfer
// PURPOSE
// - Parametrised register bank holding RTC time/date/timer words, with a sequenced
//   transfer engine to the RTC over a shared bidirectional data bus.
// - Sits between the time-set/display logic (local load port, flat register outputs)
//   and the RTC bus controller (start/done handshake, addr_ram, dato).
// - Each transaction moves one register: write = bank->RTC, read = RTC->bank.
// - Bus turnaround is explicit: dato is driven only while a write is in progress.
// PARAMETERS
// - DATA_W    8      width of each register, of dato and of addr_ram
// - N_REGS    12     number of registers; valid index range 0..N_REGS-1
// - ADDR_W    4      register index width; requires 2**ADDR_W >= N_REGS
// - HOLD_CYC  2      cycles in XFER state, 1..15; bus settle/hold time
// - BASE_ADDR 8'h00  RTC RAM address of register 0
// PORTS
// - clk       in     1               system clock, rising edge
// - reset     in     1               asynchronous, active-high
// - start     in     1               one-cycle request; sampled in IDLE only
// - wr        in     1               1 = write bank->RTC, 0 = read RTC->bank; sampled with start
// - addr      in     ADDR_W          register index; sampled with start
// - ld_en     in     1               local load strobe
// - ld_addr   in     ADDR_W          local load index
// - ld_data   in     DATA_W          local load value
// - regs_flat out    N_REGS*DATA_W   register k at bits [k*DATA_W +: DATA_W]
// - addr_ram  out    DATA_W          RTC RAM address = BASE_ADDR + latched addr
// - dato      inout  DATA_W          RTC data bus
// - busy      out    1               high while state != IDLE
// - done      out    1               one-cycle completion pulse
// - err_addr  out    1               one-cycle pulse: start with addr >= N_REGS
// BEHAVIOUR
// - Reset (async, immediate):
//   - all registers = 0; addr_ram = BASE_ADDR
//   - busy = done = err_addr = 0; dato = Z; FSM -> IDLE
//   - reset mid-transaction aborts it: no done pulse, bus released at once
// - FSM states: IDLE -> ADDR -> XFER -> DONE -> IDLE
//   - IDLE: on start with addr < N_REGS, latch wr and addr -> ADDR
//   - IDLE: on start with addr >= N_REGS, err_addr = 1 next cycle; stay IDLE
//   - ADDR (1 cycle): addr_ram valid; on a write, snapshot reg[addr] into a shadow register
//   - XFER (HOLD_CYC cycles, down-counter):
//     - write: dato = shadow
//     - read: dato = Z; capture dato into reg[addr] on the last XFER cycle
//   - DONE (1 cycle): done = 1; dato = Z -> IDLE
// - Timing, start at cycle 0: busy from cycle 1 through cycle HOLD_CYC+2;
//   done at cycle HOLD_CYC+2; next start accepted at cycle HOLD_CYC+3.
// - start while busy: ignored, not queued.
// - addr_ram holds its last value between transactions.
// - Write data is the shadow snapshot; a ld_en during XFER does not change dato.
// - ld_en is accepted in any state; ld_addr >= N_REGS is ignored silently.
// - ld_en to the same index in the read-capture cycle: bus capture wins, local load dropped.
// - dato is never driven in IDLE, ADDR, DONE, or during a read.
// CONFIGURATION
// - BCD_CHECK_EN defined:
//   - read capture validates each nibble <= 9
//   - on failure, reg[addr] keeps its old value; extra output bcd_err (1 bit) pulses with done
//   - bcd_err reset value 0
// - BCD_CHECK_EN undefined: capture unconditional; bcd_err port absent.
// TESTING
// - reset, then ld_en ld_addr=2 ld_data=8'h23, wr=1 start addr=2 -> addr_ram=8'h02 in cycle 1;
//   dato=8'h23 in cycles 2..3; done at cycle 4 (HOLD_CYC=2); dato=Z at cycle 4.
// - read addr=0, bench drives dato=8'h59 during XFER -> regs_flat[7:0]=8'h59 after done;
//   DUT never drives dato.
// - start addr=12 (N_REGS=12) -> err_addr pulse next cycle; busy stays 0; no bus activity.
// - second start during busy -> ignored: exactly one done, and addr_ram keeps the first address.
// - ld_en to addr 5 in the read-capture cycle of addr 5 -> captured bus value retained.
// - reset asserted in XFER of a write -> dato=Z and busy=0 immediately; no done;
//   BCD_CHECK_EN read of 8'h3A -> bcd_err=1, old value kept.

Source files
------------

// File: rtl/rtc_reg_bank_xfer.sv
// rtc_reg_bank_xfer: RTC register bank with a sequenced single-register transfer engine.
// Define BCD_CHECK_EN to validate read captures as BCD and add the bcd_err output.
module rtc_reg_bank_xfer #(
   parameter int                DATA_W    = 8,
   parameter int                N_REGS    = 12,
   parameter int                ADDR_W    = 4,
   parameter int                HOLD_CYC  = 2,
   parameter logic [DATA_W-1:0] BASE_ADDR = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     wr,
   input  logic [ADDR_W-1:0]        addr,
   input  logic                     ld_en,
   input  logic [ADDR_W-1:0]        ld_addr,
   input  logic [DATA_W-1:0]        ld_data,
   output logic [N_REGS*DATA_W-1:0] regs_flat,
   output logic [DATA_W-1:0]        addr_ram,
   inout  wire  [DATA_W-1:0]        dato,
   output logic                     busy,
   output logic                     done,
`ifdef BCD_CHECK_EN
   output logic                     bcd_err,
`endif
   output logic                     err_addr
);
   localparam logic [ADDR_W:0] NR       = (ADDR_W+1)'(N_REGS);
   localparam logic [3:0]      CNT_INIT = 4'(HOLD_CYC - 1);
   typedef enum logic [1:0] {IDLE, ADDR, XFER, DONE} state_t;
   state_t state, state_nx;
   logic [DATA_W-1:0] regs [N_REGS];
   logic [DATA_W-1:0] shadow;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [3:0]        cnt;
   logic              addr_ok, accept, capture, cap_ok, ld_ok;
   assign addr_ok  = {1'b0, addr} < NR;
   assign accept   = state == IDLE && start && addr_ok;
   assign capture  = state == XFER && !wr_q && cnt == '0;
   assign ld_ok    = ld_en && {1'b0, ld_addr} < NR;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign dato     = (state == XFER && wr_q) ? shadow : 'z;
`ifdef BCD_CHECK_EN
   function automatic logic bcd_ok(input logic [DATA_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i + 4 <= DATA_W; i += 4) ok = ok && v[i +: 4] <= 4'd9;
      return ok;
   endfunction
   assign cap_ok = capture && bcd_ok(dato);
   always_ff @(posedge clk or posedge reset)
      if (reset) bcd_err <= 1'b0;
      else       bcd_err <= capture && !bcd_ok(dato);
`else
   assign cap_ok = capture;
`endif
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? ADDR : IDLE;
         ADDR:    state_nx = XFER;
         XFER:    state_nx = cnt == '0 ? DONE : XFER;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         wr_q     <= 1'b0;
         cnt      <= '0;
         shadow   <= '0;
         addr_ram <= BASE_ADDR;
         err_addr <= 1'b0;
      end else begin
         err_addr <= state == IDLE && start && !addr_ok;
         if (accept) begin
            addr_q   <= addr;
            wr_q     <= wr;
            addr_ram <= BASE_ADDR + DATA_W'(addr);
         end
         // write data is frozen here so later local loads cannot disturb the bus
         if (state == ADDR) begin
            cnt <= CNT_INIT;
            if (wr_q) shadow <= regs[addr_q];
         end
         if (state == XFER && cnt != '0) cnt <= cnt - 4'd1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      end else begin
         if (ld_ok) regs[ld_addr] <= ld_data;
         if (cap_ok) regs[addr_q] <= dato;
      end
   end
   for (genvar k = 0; k < N_REGS; k++) begin : g_flat
      assign regs_flat[k*DATA_W +: DATA_W] = regs[k];
   end
endmodule
